// File: rtl/ni_pkg.sv
// Shared constants, FSM encoding and fanout-slot helper for the spike
// network-interface dispatcher.
package ni_pkg;

  localparam int unsigned NUM_BITS_ADDR   = 12;
  localparam int unsigned NUM_CONNECTIONS = 5;
  localparam int unsigned ADDRSIZE        = NUM_BITS_ADDR * NUM_CONNECTIONS;
  localparam int unsigned CNT_BITS        = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    EMIT
  } state_t;

  // Slot 0 sits in the MSBs; shifting left brings slot k to the top field.
  function automatic logic [NUM_BITS_ADDR-1:0] slot_extract(
    input logic [ADDRSIZE-1:0] vec,
    input logic [CNT_BITS-1:0] k
  );
    logic [ADDRSIZE-1:0] shifted;
    shifted = vec << (int'(k) * NUM_BITS_ADDR);
    return shifted[ADDRSIZE-1 -: NUM_BITS_ADDR];
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO buffering spiking source addresses; DEPTH must be a
// power of two (>= 2) so the pointers wrap naturally.
module spike_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spike_fanout_dispatcher.sv
// Buffers spiking sources, looks up their fanout and serialises one
// valid/ready packet per destination toward the NoC router.
module spike_fanout_dispatcher
  import ni_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spike_valid,
  output logic                     spike_ready,
  input  logic [NUM_BITS_ADDR-1:0] spike_addr,
  output logic [NUM_BITS_ADDR-1:0] fo_src_addr,
  input  logic [ADDRSIZE-1:0]      fo_dest_addrs,
  input  logic [CNT_BITS-1:0]      fo_count,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic [NUM_BITS_ADDR-1:0] pkt_src,
  output logic [NUM_BITS_ADDR-1:0] pkt_dest,
  output logic                     pkt_last,
  output logic                     busy
);

  localparam logic [CNT_BITS-1:0] MAX_CNT = NUM_CONNECTIONS[CNT_BITS-1:0];

  state_t                   state;
  state_t                   state_next;
  logic [NUM_BITS_ADDR-1:0] src_reg;
  logic [ADDRSIZE-1:0]      vec_reg;
  logic [CNT_BITS-1:0]      cnt_reg;
  logic [CNT_BITS-1:0]      slot;
  logic [CNT_BITS-1:0]      cnt_clamped;
  logic                     is_last;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [NUM_BITS_ADDR-1:0] fifo_dout;

  spike_fifo #(
    .WIDTH(NUM_BITS_ADDR),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (spike_valid),
    .pop  (pop),
    .din  (spike_addr),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign spike_ready = !fifo_full;
  assign fo_src_addr = src_reg;
  assign busy        = (state != IDLE) || !fifo_empty;
  assign cnt_clamped = (fo_count > MAX_CNT) ? MAX_CNT : fo_count;
  assign is_last     = (slot == cnt_reg - 1'b1);

  // Packet fields are forced to zero outside EMIT so unused slots never leak.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    pkt_valid  = 1'b0;
    pkt_src    = '0;
    pkt_dest   = '0;
    pkt_last   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        state_next = (cnt_clamped == '0) ? IDLE : EMIT;
      end
      EMIT: begin
        pkt_valid = 1'b1;
        pkt_src   = src_reg;
        pkt_dest  = slot_extract(vec_reg, slot);
        pkt_last  = is_last;
        if (pkt_ready && is_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      src_reg <= '0;
      vec_reg <= '0;
      cnt_reg <= '0;
      slot    <= '0;
    end else begin
      state <= state_next;
      if (pop) src_reg <= fifo_dout;
      if (state == LOOKUP) begin
        vec_reg <= fo_dest_addrs;
        cnt_reg <= cnt_clamped;
        slot    <= '0;
      end
      if (state == EMIT && pkt_ready && !is_last) slot <= slot + 1'b1;
    end
  end

endmodule
